pipe_hs_reg: RTL

- Parametrised, handshaked pipeline stage register for the pipelined CPU.
- Generalises the fixed MEM/WB latch in four ways:
  - configurable control, data and register-number widths;
  - valid/ready flow control, for stall back-pressure;
  - synchronous flush, for bubble insertion;
  - optional one-entry skid buffer, so in_ready carries no combinational path from out_ready.
- Sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB).
- Carries control bits, two data words and a destination register number.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_slot.sv | 40 ++++
 rtl/pipe_hs_reg.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the handshaked pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int RN_W_DEF   = 5;

endpackage

// File: rtl/pipe_slot.sv
// One payload register (ctrl + two data words + register number) with load enable.
// clr zeroes only the control bits; the data fields are allowed to go stale.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W   = RN_W_DEF
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              load,
  input  logic              clr,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_d0,
  input  logic [DATA_W-1:0] d_d1,
  input  logic [RN_W-1:0]   d_rn,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_d0,
  output logic [DATA_W-1:0] q_d1,
  output logic [RN_W-1:0]   q_rn
);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_ctrl <= '0;
      q_d0   <= '0;
      q_d1   <= '0;
      q_rn   <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_d0   <= d_d0;
      q_d1   <= d_d1;
      q_rn   <= d_rn;
    end
  end

endmodule

// File: rtl/pipe_hs_reg.sv
// Valid/ready pipeline stage register with synchronous flush and optional skid slot.
// state    | meaning
// ST_EMPTY | M invalid, can accept
// ST_FULL  | M valid, S empty, can accept
// ST_SKID  | M and S valid, in_ready low (SKID=1 only)
module pipe_hs_reg
  import pipe_pkg::*;
#(
  parameter int NCTRL  = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RN_W   = RN_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCTRL-1:0]  in_ctrl,
  input  logic [DATA_W-1:0] in_d0,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [RN_W-1:0]   in_rn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCTRL-1:0]  out_ctrl,
  output logic [DATA_W-1:0] out_d0,
  output logic [DATA_W-1:0] out_d1,
  output logic [RN_W-1:0]   out_rn
);

  localparam bit HAS_SKID = (SKID != 0);

  pipe_state_e state_q, state_d;

  logic accept, emit;
  logic m_load, s_load, m_from_s, slot_clr;

  logic [NCTRL-1:0]  m_ctrl, s_ctrl, m_in_ctrl;
  logic [DATA_W-1:0] s_d0, s_d1, m_in_d0, m_in_d1;
  logic [RN_W-1:0]   s_rn, m_in_rn;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = HAS_SKID ? (state_q != ST_SKID) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    m_load   = 1'b0;
    s_load   = 1'b0;
    m_from_s = 1'b0;
    slot_clr = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      slot_clr = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            m_load  = 1'b1;
          end
        end
        ST_FULL: begin
          if (accept && emit) begin
            m_load = 1'b1;
          end else if (emit) begin
            state_d = ST_EMPTY;
          end else if (accept && HAS_SKID) begin
            state_d = ST_SKID;
            s_load  = 1'b1;
          end
        end
        ST_SKID: begin
          if (emit) begin
            state_d  = ST_FULL;
            m_load   = 1'b1;
            m_from_s = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign m_in_ctrl = m_from_s ? s_ctrl : in_ctrl;
  assign m_in_d0   = m_from_s ? s_d0   : in_d0;
  assign m_in_d1   = m_from_s ? s_d1   : in_d1;
  assign m_in_rn   = m_from_s ? s_rn   : in_rn;

  pipe_slot #(.CTRL_W(NCTRL), .DATA_W(DATA_W), .RN_W(RN_W)) u_m (
    .clk    (clk),
    .clrn   (clrn),
    .load   (m_load),
    .clr    (slot_clr),
    .d_ctrl (m_in_ctrl),
    .d_d0   (m_in_d0),
    .d_d1   (m_in_d1),
    .d_rn   (m_in_rn),
    .q_ctrl (m_ctrl),
    .q_d0   (out_d0),
    .q_d1   (out_d1),
    .q_rn   (out_rn)
  );

  generate
    if (HAS_SKID) begin : g_skid
      pipe_slot #(.CTRL_W(NCTRL), .DATA_W(DATA_W), .RN_W(RN_W)) u_s (
        .clk    (clk),
        .clrn   (clrn),
        .load   (s_load),
        .clr    (slot_clr),
        .d_ctrl (in_ctrl),
        .d_d0   (in_d0),
        .d_d1   (in_d1),
        .d_rn   (in_rn),
        .q_ctrl (s_ctrl),
        .q_d0   (s_d0),
        .q_d1   (s_d1),
        .q_rn   (s_rn)
      );
    end else begin : g_noskid
      assign s_ctrl = '0;
      assign s_d0   = '0;
      assign s_d1   = '0;
      assign s_rn   = '0;
    end
  endgenerate

  // M keeps its ctrl after a plain drain, so gate it to keep bubbles harmless.
  assign out_ctrl = m_ctrl & {NCTRL{out_valid}};

endmodule
